instr_fetch_unit: RTL

//   Instruction producer for the sequential RISC-V core: owns the PC, fetches 32-bit words

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/instr_fetch_unit_fetch_buffer.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Definitions shared across the core: widths, reset vector, fetch states and base opcodes.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // RV32I major opcodes, also decoded by control_unit
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Small shift-register FIFO of {pc, instr}; the head always sits in entry 0 so the
// outputs come straight from flops.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [AW-1:0]   push_pc,
   input  logic [ILEN-1:0] push_instr,
   input  logic            pop,
   input  logic            flush,
   output logic            valid,
   output logic            full,
   output logic [CW-1:0]   count_nxt,
   output logic [AW-1:0]   head_pc,
   output logic [ILEN-1:0] head_instr
);

   logic [CW-1:0]   count;
   logic [CW-1:0]   wr_idx;
   logic [AW-1:0]   pc_q    [DEPTH];
   logic [ILEN-1:0] instr_q [DEPTH];

   assign full       = (count == CW'(DEPTH));
   assign wr_idx     = pop ? count - CW'(1) : count;
   assign head_pc    = pc_q[0];
   assign head_instr = instr_q[0];

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + CW'(1);
      else if (pop && !push)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         count <= count_nxt;
         valid <= (count_nxt != '0);
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               pc_q[i]    <= pc_q[i+1];
               instr_q[i] <= instr_q[i+1];
            end
         end
         // a push lands behind the survivors of a simultaneous pop
         for (int i = 0; i < DEPTH; i++) begin
            if (push && !flush && wr_idx == CW'(i)) begin
               pc_q[i]    <= push_pc;
               instr_q[i] <= push_instr;
            end
         end
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time, buffers returned
// words and hands {pc, instr} to decode; redirects restart fetch and flush stale data.
//
// state | meaning
// REQ   | request pc while buffer has room; gnt moves to WAIT
// WAIT  | one request outstanding; rvalid pushes the word into the buffer
// DROP  | outstanding request was overtaken by a redirect; rvalid is discarded
module instr_fetch_unit #(
   parameter int              XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
   parameter int              BUF_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic                      imem_req,
   output logic [XLEN-1:0]           imem_addr,
   input  logic                      imem_gnt,
   input  logic                      imem_rvalid,
   input  logic [riscv_pkg::ILEN-1:0] imem_rdata,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [riscv_pkg::ILEN-1:0] instr_out,
   output logic [XLEN-1:0]           instr_pc
);
   import riscv_pkg::*;

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt, pc_req;
   logic            req_fire, push, pop, buf_full;
   logic [CW-1:0]   count_nxt;

   assign req_fire = imem_req && imem_gnt;
   assign pop      = instr_valid && instr_ready;
   assign push     = (state == WAIT) && imem_rvalid && !redirect_valid && !buf_full;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         REQ: begin
            if (req_fire) begin
               state_nxt = WAIT;
               pc_nxt    = pc + XLEN'(4);
            end
         end
         WAIT, DROP: begin
            if (imem_rvalid)
               state_nxt = REQ;
         end
         default: state_nxt = REQ;
      endcase
      // a redirect overrides the PC; an in-flight or just-granted request becomes stale
      if (redirect_valid) begin
         pc_nxt = redirect_pc & ~XLEN'(3);
         if (state == REQ && req_fire)
            state_nxt = DROP;
         else if (state == WAIT && !imem_rvalid)
            state_nxt = DROP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= REQ;
         pc        <= RESET_PC;
         pc_req    <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         if (req_fire)
            pc_req <= imem_addr;
         // no request outstanding in REQ, so room is judged on the buffer alone
         imem_req  <= (state_nxt == REQ) && (count_nxt < CW'(BUF_DEPTH));
         imem_addr <= pc_nxt;
      end
   end

   fetch_buffer #(
      .AW    (XLEN),
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_pc    (pc_req),
      .push_instr (imem_rdata),
      .pop        (pop),
      .flush      (redirect_valid),
      .valid      (instr_valid),
      .full       (buf_full),
      .count_nxt  (count_nxt),
      .head_pc    (instr_pc),
      .head_instr (instr_out)
   );

endmodule
